// File: rtl/err_meas_pkg.sv
//------------------------------------------------------------------------------
// Module : err_meas_pkg
// Brief  : Shared state encoding, width helpers and defaults for the
//          squared-error measurement sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package err_meas_pkg;

    // Default window length (log2 of clk_en ticks).
    localparam int DEF_WIN_LOG2 = 4;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ACCUM  = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        SETTLE = ST_SETTLE,
        ACCUM  = ST_ACCUM,
        FLUSH  = ST_FLUSH,
        DONE   = ST_DONE
    } state_t;

    // Squared error is < 2^18 and at most 2^win_log2 terms are summed.
    function automatic int acc_width(input int win_log2);
        return 18 + win_log2;
    endfunction

    // One extra bit so the counter target can hold 2^win_log2 itself.
    function automatic int cnt_width(input int win_log2);
        return win_log2 + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIN_LOG2);
    localparam int ACC_W = acc_width(DEF_WIN_LOG2);

endpackage

`default_nettype wire

// File: rtl/err_meas_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : err_meas_ctrl_if
// Brief  : Request/result handshake plus accumulator control signals of the
//          measurement sequencer. slave = sequencer, master = environment.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface err_meas_ctrl_if
   import err_meas_pkg::*;
#(
   parameter int ACC_W = err_meas_pkg::ACC_W
);
   logic             clk_en;
   logic             start;
   logic             abort;
   logic [ACC_W-1:0] acc_in;
   logic             result_ack;
   logic             acc_clear;
   logic             acc_hold;
   logic             busy;
   logic [ACC_W-1:0] result;
   logic             result_valid;
   logic             overrun;
   logic [7:0]       meas_count;

   modport slave (
      input  clk_en, start, abort, acc_in, result_ack,
      output acc_clear, acc_hold, busy, result, result_valid, overrun, meas_count
   );

   modport master (
      output clk_en, start, abort, acc_in, result_ack,
      input  acc_clear, acc_hold, busy, result, result_valid, overrun, meas_count
   );
endinterface

`default_nettype wire

// File: rtl/err_meas_tick_cnt.sv
//------------------------------------------------------------------------------
// Module : err_meas_tick_cnt
// Brief  : Enable-gated tick counter with clear and a loadable target.
//          o_term pulses on the enabled tick that reaches the target; the
//          counter then restarts from zero for the next phase.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module err_meas_tick_cnt
   import err_meas_pkg::*;
#(
   parameter int CNT_W = err_meas_pkg::CNT_W
) (
   input  wire             clk,
   input  wire             reset,
   input  wire             i_clr,
   input  wire             i_en,
   input  wire [CNT_W-1:0] i_target,
   output logic            o_term
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   // Clear wins over a same-cycle terminal tick.
   assign o_term    = i_en && !i_clr && (w_cnt_inc == i_target);

   // Count enabled ticks; restart on clear or on reaching the target.
   always_ff @(posedge clk) begin
      if (reset || i_clr || o_term) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_cnt_inc;
      end
   end
endmodule

`default_nettype wire

// File: rtl/err_meas_ctrl.sv
//------------------------------------------------------------------------------
// Module : err_meas_ctrl
// Brief  : Sequencer for the squared-error accumulator: clear, settle,
//          accumulate exactly 2^WIN_LOG2 clk_en ticks, flush, capture and
//          hand the sum over with a valid/ack handshake.
//          Build macro ERR_MEAS_AUTO_EN selects continuous (auto-restart)
//          mode with a sticky overrun flag; otherwise one-shot.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module err_meas_ctrl
   import err_meas_pkg::*;
#(
   parameter int WIN_LOG2     = err_meas_pkg::DEF_WIN_LOG2,
   parameter int SETTLE_TICKS = 2,
   parameter int FLUSH_TICKS  = 2,
   parameter int ACC_W        = acc_width(WIN_LOG2)
) (
   input  wire              clk,
   input  wire              reset,
   err_meas_ctrl_if.slave   bus
);
   localparam int               c_CNT_W      = cnt_width(WIN_LOG2);
   localparam logic [c_CNT_W-1:0] c_SETTLE_TGT = c_CNT_W'(SETTLE_TICKS);
   localparam logic [c_CNT_W-1:0] c_WIN_TGT    = c_CNT_W'(2 ** WIN_LOG2);
   localparam logic [c_CNT_W-1:0] c_FLUSH_TGT  = c_CNT_W'(FLUSH_TICKS);

   state_t             r_state;
   state_t             w_next;
   logic               w_capture;
   logic               w_counting;
   logic               w_cnt_clr;
   logic               w_cnt_en;
   logic               w_tick_done;
   logic [c_CNT_W-1:0] w_target;

   logic               r_acc_clear;
   logic               r_acc_hold;
   logic               r_busy;
   logic [ACC_W-1:0]   r_result;
   logic               r_result_valid;
   logic [7:0]         r_meas_count;

   assign w_counting = (r_state == SETTLE) || (r_state == ACCUM) || (r_state == FLUSH);
   // Abort also clears the counter so a later run always starts from zero.
   assign w_cnt_clr  = !w_counting || bus.abort;
   assign w_cnt_en   = w_counting && bus.clk_en;

   // Select the tick target of the phase currently being timed.
   always_comb begin
      w_target = c_FLUSH_TGT;
      case (r_state)
         SETTLE:  w_target = c_SETTLE_TGT;
         ACCUM:   w_target = c_WIN_TGT;
         default: w_target = c_FLUSH_TGT;
      endcase
   end

   err_meas_tick_cnt #(
      .CNT_W (c_CNT_W)
   ) u_tick_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .i_target (w_target),
      .o_term   (w_tick_done)
   );

   // Next-state decode; abort beats a same-cycle terminal tick.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      case (r_state)
         IDLE:   if (bus.start) w_next = CLEAR;
         CLEAR:  w_next = SETTLE;
         SETTLE: begin
            if (bus.abort)        w_next = IDLE;
            else if (w_tick_done) w_next = ACCUM;
         end
         ACCUM: begin
            if (bus.abort)        w_next = IDLE;
            else if (w_tick_done) w_next = FLUSH;
         end
         FLUSH: begin
            if (bus.abort) begin
               w_next = IDLE;
            end else if (w_tick_done) begin
               w_capture = 1'b1;
`ifdef ERR_MEAS_AUTO_EN
               w_next    = CLEAR;
`else
               w_next    = DONE;
`endif
            end
         end
         DONE:    if (bus.result_ack) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register; control outputs registered from next state so they are
   // glitch-free and line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_acc_clear <= 1'b0;
         r_acc_hold  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_acc_clear <= (w_next == CLEAR);
         r_acc_hold  <= (w_next != ACCUM);
         r_busy      <= !((w_next == IDLE) || (w_next == DONE));
      end
   end

`ifdef ERR_MEAS_AUTO_EN
   logic r_overrun;

   // Capture path in continuous mode; an unacked result being replaced
   // raises the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_meas_count   <= 8'd0;
         r_overrun      <= 1'b0;
      end else if (w_capture) begin
         r_result       <= bus.acc_in;
         r_result_valid <= 1'b1;
         r_meas_count   <= r_meas_count + 8'd1;
         if (r_result_valid && !bus.result_ack) r_overrun <= 1'b1;
      end else if (bus.result_ack) begin
         r_result_valid <= 1'b0;
      end
   end

   assign bus.overrun = r_overrun;
`else
   // Capture path in one-shot mode; the result is released by ack in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_meas_count   <= 8'd0;
      end else if (w_capture) begin
         r_result       <= bus.acc_in;
         r_result_valid <= 1'b1;
         r_meas_count   <= r_meas_count + 8'd1;
      end else if ((r_state == DONE) && bus.result_ack) begin
         r_result_valid <= 1'b0;
      end
   end

   assign bus.overrun = 1'b0;
`endif

   assign bus.acc_clear    = r_acc_clear;
   assign bus.acc_hold     = r_acc_hold;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.meas_count   = r_meas_count;
endmodule

`default_nettype wire

// File: tb/tb_err_meas_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_err_meas_ctrl
// Brief  : Bench for err_meas_ctrl with a behavioural squared-error
//          accumulator (input stage, accumulator, output register, each
//          advancing on clk_en). Captures are checked by a scoreboard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_err_meas_ctrl;
   localparam int WIN_LOG2 = 4;
   localparam int ACC_W    = 22;

   typedef struct {
      logic [ACC_W-1:0] res;
      logic [7:0]       cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_err;
   int   en_period;
   int   ph;
   int   hold_cycles;
   int   hold_ticks;
   int   clear_cycles;
   exp_t exp_q[$];

   logic signed [17:0] err;
   logic signed [35:0] prod;
   logic [ACC_W-1:0]   m_sq;
   logic [ACC_W-1:0]   m_acc;
   logic [ACC_W-1:0]   m_out;

   err_meas_ctrl_if #(.ACC_W(ACC_W)) bus ();

   err_meas_ctrl #(
      .WIN_LOG2     (WIN_LOG2),
      .SETTLE_TICKS (2),
      .FLUSH_TICKS  (2),
      .ACC_W        (ACC_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Accumulator model: squared error scaled by 2^-17, reset by acc_clear|reset.
   assign prod       = err * err;
   assign bus.acc_in = m_out;
   always @(posedge clk) begin
      if (reset || bus.acc_clear) begin
         m_sq  <= '0;
         m_acc <= '0;
         m_out <= '0;
      end else if (bus.clk_en) begin
         m_sq  <= ACC_W'(prod >> 17);
         if (!bus.acc_hold) m_acc <= m_acc + m_sq;
         m_out <= m_acc;
      end
   end

   // clk_en: one cycle in en_period.
   initial begin
      en_period  = 1;
      ph         = 0;
      bus.clk_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ph         = (ph + 1) % en_period;
         bus.clk_en = (ph == 0);
      end
   end

   // Activity counters used by the directed checks.
   initial begin
      hold_cycles  = 0;
      hold_ticks   = 0;
      clear_cycles = 0;
      forever begin
         @(negedge clk);
         if (!bus.acc_hold) hold_cycles++;
         if (!bus.acc_hold && bus.clk_en) hold_ticks++;
         if (bus.acc_clear) clear_cycles++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Scoreboard monitor: every meas_count step outside reset is a capture.
   initial begin : monitor
      logic [7:0] prev_cnt;
      exp_t       e;
      prev_cnt = 8'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_cnt = bus.meas_count;
         end else if (bus.meas_count != prev_cnt) begin
            prev_cnt = bus.meas_count;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL capture_unexpected: got result %0d count %0d, required no capture",
                        bus.result, bus.meas_count);
            end else begin
               e = exp_q.pop_front();
               chk("capture_result", 32'(bus.result), 32'(e.res));
               chk("capture_count", 32'(bus.meas_count), 32'(e.cnt));
               chk("capture_valid", 32'(bus.result_valid), 32'd1);
            end
         end
      end
   end

   task automatic zero_counters();
      hold_cycles  = 0;
      hold_ticks   = 0;
      clear_cycles = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   task automatic do_ack();
      @(posedge clk); #1 bus.result_ack = 1'b1;
      @(posedge clk); #1 bus.result_ack = 1'b0;
      @(negedge clk);
      chk("ack_valid_low", 32'(bus.result_valid), 32'd0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!bus.result_valid && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (!bus.result_valid) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: result_valid still 0 after %0d cycles, required 1", name, budget);
      end
   endtask

   task automatic wait_ticks(input string name, input int t, input int budget);
      int n = 0;
      while (hold_ticks < t && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (hold_ticks < t) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: accumulate ticks %0d after %0d cycles, required %0d", name, hold_ticks, budget, t);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_acc_clear"},    32'(bus.acc_clear), 32'd0);
      chk({tag, "_acc_hold"},     32'(bus.acc_hold), 32'd1);
      chk({tag, "_busy"},         32'(bus.busy), 32'd0);
      chk({tag, "_result"},       32'(bus.result), 32'd0);
      chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_overrun"},      32'(bus.overrun), 32'd0);
      chk({tag, "_meas_count"},   32'(bus.meas_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      n_checks       = 0;
      n_err          = 0;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.result_ack = 1'b0;
      err            = 18'sh10000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values("rst");
      #1 reset = 1'b0;

`ifdef ERR_MEAS_AUTO_EN
      // Continuous mode: two captures without ack, then stop with abort.
      zero_counters();
      exp_q.push_back('{res: 22'd524288, cnt: 8'd1});
      exp_q.push_back('{res: 22'd524288, cnt: 8'd2});
      pulse_start();
      begin
         int n = 0;
         while (bus.meas_count != 8'd2 && n < 200) begin
            @(negedge clk); #1;
            n++;
         end
      end
      chk("auto_count", 32'(bus.meas_count), 32'd2);
      chk("auto_overrun", 32'(bus.overrun), 32'd1);
      chk("auto_valid", 32'(bus.result_valid), 32'd1);
      bus.abort = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.abort = 1'b0;
      @(negedge clk);
      chk("auto_abort_busy", 32'(bus.busy), 32'd0);
      do_ack();
      chk("auto_ack_overrun", 32'(bus.overrun), 32'd1);
      chk("auto_ack_count", 32'(bus.meas_count), 32'd2);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("auto_stopped_busy", 32'(bus.busy), 32'd0);
`else
      // 1: continuous clk_en.
      zero_counters();
      exp_q.push_back('{res: 22'd524288, cnt: 8'd1});
      pulse_start();
      wait_valid("t1_wait", 200);
      chk("t1_hold_cycles", 32'(hold_cycles), 32'd16);
      chk("t1_hold_ticks", 32'(hold_ticks), 32'd16);
      chk("t1_clear_cycles", 32'(clear_cycles), 32'd1);
      chk("t1_busy_done", 32'(bus.busy), 32'd0);
      do_ack();

      // 2: clk_en one in four.
      en_period = 4;
      zero_counters();
      exp_q.push_back('{res: 22'd524288, cnt: 8'd2});
      pulse_start();
      wait_valid("t2_wait", 400);
      chk("t2_hold_cycles", 32'(hold_cycles), 32'd64);
      chk("t2_hold_ticks", 32'(hold_ticks), 32'd16);
      chk("t2_clear_cycles", 32'(clear_cycles), 32'd1);
      do_ack();

      // 3: abort at accumulate tick 7, restart, then abort on the last tick.
      en_period = 1;
      zero_counters();
      pulse_start();
      wait_ticks("t3_wait7", 7, 100);
      bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      @(negedge clk);
      chk("t3_abort_busy", 32'(bus.busy), 32'd0);
      chk("t3_abort_hold", 32'(bus.acc_hold), 32'd1);
      chk("t3_abort_valid", 32'(bus.result_valid), 32'd0);
      chk("t3_abort_count", 32'(bus.meas_count), 32'd2);
      zero_counters();
      exp_q.push_back('{res: 22'd524288, cnt: 8'd3});
      pulse_start();
      wait_valid("t3_restart_wait", 200);
      do_ack();
      zero_counters();
      pulse_start();
      wait_ticks("t3_wait16", 16, 100);
      bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t3_last_tick_abort_busy", 32'(bus.busy), 32'd0);
      chk("t3_last_tick_abort_count", 32'(bus.meas_count), 32'd3);

      // 4: start held high through the run is ignored; start in DONE ignored.
      zero_counters();
      exp_q.push_back('{res: 22'd524288, cnt: 8'd4});
      @(posedge clk); #1 bus.start = 1'b1;
      wait_valid("t4_wait", 200);
      bus.start = 1'b0;
      chk("t4_clear_cycles", 32'(clear_cycles), 32'd1);
      chk("t4_hold_cycles", 32'(hold_cycles), 32'd16);
      pulse_start();
      @(negedge clk);
      chk("t4_done_busy", 32'(bus.busy), 32'd0);
      chk("t4_done_valid", 32'(bus.result_valid), 32'd1);
      chk("t4_done_count", 32'(bus.meas_count), 32'd4);
      do_ack();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t4_idle_busy", 32'(bus.busy), 32'd0);

      // Reset in the middle of the window.
      zero_counters();
      pulse_start();
      wait_ticks("t4_wait5", 5, 100);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_values("midrst");
      #1 reset = 1'b0;

      // 6: most negative error, sparse clk_en.
      err       = 18'sh20000;
      en_period = 4;
      zero_counters();
      exp_q.push_back('{res: 22'd2097152, cnt: 8'd1});
      pulse_start();
      wait_valid("t6_wait", 400);
      chk("t6_hold_ticks", 32'(hold_ticks), 32'd16);
      do_ack();
`endif

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
